// File: rtl/uart_core_param_if.sv
// Handshake bundle for uart_core_param: transmit valid/ready path and
// receive word/flag outputs. The serial lines stay plain ports on the core.
interface uart_core_param_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx_busy;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_parity_err;
   logic              rx_frame_err;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
   );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: framed transmitter, mid-bit sampling receiver
// with parity/framing checks and a run-time tx-to-rx loopback.
module uart_core_param #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   uart_core_param_if.slave      bus,
   output logic                  uart_tx,
   input  logic                  uart_rx,
   input  logic                  loopback
);

   localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
   localparam int IDX_W = $clog2(DATA_W);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   // The FSM leaves STOP one cycle early; the idle cycle that follows
   // completes the last stop bit, so back-to-back frames keep exact timing.
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 2);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
   localparam logic             ODD_BIT   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   function automatic logic calc_parity(input logic [DATA_W-1:0] word);
      return (^word) ^ ODD_BIT;
   endfunction

   uart_state_t        tx_state_r;
   logic [CNT_W-1:0]   tx_cnt_r;
   logic [IDX_W-1:0]   tx_idx_r;
   logic [DATA_W-1:0]  tx_shift_r;
   logic               tx_par_r;
   logic               tx_line_r;
   logic               tx_ready_r;
   logic               tx_busy_r;

   uart_state_t        rx_state_r;
   logic [CNT_W-1:0]   rx_cnt_r;
   logic [IDX_W-1:0]   rx_idx_r;
   logic [DATA_W-1:0]  rx_shift_r;
   logic               rx_perr_pend_r;
   logic               sync1_r;
   logic               sync2_r;
   logic               rx_src_s;
   logic [DATA_W-1:0]  rx_data_r;
   logic               rx_valid_r;
   logic               rx_perr_r;
   logic               rx_ferr_r;

   assign uart_tx          = tx_line_r;
   assign bus.tx_ready     = tx_ready_r;
   assign bus.tx_busy      = tx_busy_r;
   assign bus.rx_data      = rx_data_r;
   assign bus.rx_valid     = rx_valid_r;
   assign bus.rx_parity_err = rx_perr_r;
   assign bus.rx_frame_err = rx_ferr_r;

   // Transmit FSM: accepts a word, then serialises start, data, parity, stop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_r <= ST_IDLE;
         tx_cnt_r   <= '0;
         tx_idx_r   <= '0;
         tx_shift_r <= '0;
         tx_par_r   <= 1'b0;
         tx_line_r  <= 1'b1;
         tx_ready_r <= 1'b1;
         tx_busy_r  <= 1'b0;
      end else begin
         case (tx_state_r)
            ST_IDLE: begin
               if (bus.tx_valid) begin
                  tx_shift_r <= bus.tx_data;
                  tx_par_r   <= calc_parity(bus.tx_data);
                  tx_line_r  <= 1'b0;
                  tx_ready_r <= 1'b0;
                  tx_busy_r  <= 1'b1;
                  tx_cnt_r   <= '0;
                  tx_state_r <= ST_START;
               end else begin
                  tx_line_r  <= 1'b1;
                  tx_ready_r <= 1'b1;
                  tx_busy_r  <= 1'b0;
               end
            end
            ST_START: begin
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r   <= '0;
                  tx_idx_r   <= '0;
                  tx_line_r  <= tx_shift_r[0];
                  tx_state_r <= ST_DATA;
               end else begin
                  tx_cnt_r <= tx_cnt_r + 1'b1;
               end
            end
            ST_DATA: begin
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r <= '0;
                  if (tx_idx_r == IDX_LAST) begin
                     if (PARITY_EN != 0) begin
                        tx_line_r  <= tx_par_r;
                        tx_state_r <= ST_PARITY;
                     end else begin
                        tx_line_r  <= 1'b1;
                        tx_state_r <= ST_STOP;
                     end
                  end else begin
                     tx_idx_r   <= tx_idx_r + 1'b1;
                     tx_shift_r <= {1'b0, tx_shift_r[DATA_W-1:1]};
                     tx_line_r  <= tx_shift_r[1];
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + 1'b1;
               end
            end
            ST_PARITY: begin
               if (tx_cnt_r == BIT_LAST) begin
                  tx_cnt_r   <= '0;
                  tx_line_r  <= 1'b1;
                  tx_state_r <= ST_STOP;
               end else begin
                  tx_cnt_r <= tx_cnt_r + 1'b1;
               end
            end
            ST_STOP: begin
               if (tx_cnt_r == STOP_LAST) begin
                  tx_cnt_r   <= '0;
                  tx_ready_r <= 1'b1;
                  tx_busy_r  <= 1'b0;
                  tx_state_r <= ST_IDLE;
               end else begin
                  tx_cnt_r <= tx_cnt_r + 1'b1;
               end
            end
            default: begin
               tx_state_r <= ST_IDLE;
               tx_line_r  <= 1'b1;
               tx_ready_r <= 1'b1;
               tx_busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Receive source select: loopback taps the registered transmit line.
   always_comb begin
      rx_src_s = 1'b1;
      if (loopback) begin
         rx_src_s = tx_line_r;
      end else begin
         rx_src_s = uart_rx;
      end
   end

   // Two-flop synchroniser for the asynchronous serial input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx_src_s;
         sync2_r <= sync1_r;
      end
   end

   // Receive FSM: validates the start bit at its midpoint, then samples bit centres.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_r     <= ST_IDLE;
         rx_cnt_r       <= '0;
         rx_idx_r       <= '0;
         rx_shift_r     <= '0;
         rx_perr_pend_r <= 1'b0;
         rx_data_r      <= '0;
         rx_valid_r     <= 1'b0;
         rx_perr_r      <= 1'b0;
         rx_ferr_r      <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         case (rx_state_r)
            ST_IDLE: begin
               if (!sync2_r) begin
                  rx_cnt_r       <= '0;
                  rx_perr_pend_r <= 1'b0;
                  rx_state_r     <= ST_START;
               end else begin
                  rx_cnt_r <= '0;
               end
            end
            ST_START: begin
               if (rx_cnt_r == HALF_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_idx_r   <= '0;
                  rx_state_r <= sync2_r ? ST_IDLE : ST_DATA;
               end else begin
                  rx_cnt_r <= rx_cnt_r + 1'b1;
               end
            end
            ST_DATA: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_shift_r <= {sync2_r, rx_shift_r[DATA_W-1:1]};
                  if (rx_idx_r == IDX_LAST) begin
                     rx_state_r <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     rx_idx_r <= rx_idx_r + 1'b1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + 1'b1;
               end
            end
            ST_PARITY: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r       <= '0;
                  rx_perr_pend_r <= (sync2_r != calc_parity(rx_shift_r));
                  rx_state_r     <= ST_STOP;
               end else begin
                  rx_cnt_r <= rx_cnt_r + 1'b1;
               end
            end
            ST_STOP: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_valid_r <= 1'b1;
                  rx_data_r  <= rx_shift_r;
                  rx_perr_r  <= rx_perr_pend_r;
                  rx_ferr_r  <= ~sync2_r;
                  rx_state_r <= ST_IDLE;
               end else begin
                  rx_cnt_r <= rx_cnt_r + 1'b1;
               end
            end
            default: begin
               rx_state_r <= ST_IDLE;
               rx_cnt_r   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench for uart_core_param: a default 8N1 instance (loopback and
// external frames) and an 8O1 instance fed with external parity frames.
module tb_uart_core_param;

   localparam int CPB = 16;

   typedef struct {
      logic [7:0] d;
      logic       perr;
      logic       ferr;
      int         t_acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic lb  = 1'b1;
   logic ext_rx = 1'b1;
   logic ext_rx_p = 1'b1;
   logic uart_tx, uart_tx_p;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   exp_t qp[$];

   uart_core_param_if #(.DATA_W(8)) bus ();
   uart_core_param_if #(.DATA_W(8)) bus_p ();

   uart_core_param dut (
      .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx),
      .uart_rx(ext_rx), .loopback(lb)
   );

   uart_core_param #(.PARITY_EN(1), .PARITY_ODD(1)) dut_p (
      .clk(clk), .rst(rst), .bus(bus_p), .uart_tx(uart_tx_p),
      .uart_rx(ext_rx_p), .loopback(1'b0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitors: pop the oldest expectation whenever a word is presented.
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (rst && bus.rx_valid) begin
         check("rx_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("rx_data", 32'(bus.rx_data), 32'(e.d));
            check("rx_parity_err", 32'(bus.rx_parity_err), 32'(e.perr));
            check("rx_frame_err", 32'(bus.rx_frame_err), 32'(e.ferr));
            if (e.t_acc >= 0) begin
               lat = cyc - e.t_acc;
               check("rx_latency", (lat >= 154 && lat <= 156) ? 32'd155 : 32'(lat), 32'd155);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst && bus_p.rx_valid) begin
         check("rxp_expected", 32'(qp.size() > 0), 32'd1);
         if (qp.size() > 0) begin
            e = qp.pop_front();
            check("rxp_data", 32'(bus_p.rx_data), 32'(e.d));
            check("rxp_parity_err", 32'(bus_p.rx_parity_err), 32'(e.perr));
            check("rxp_frame_err", 32'(bus_p.rx_frame_err), 32'(e.ferr));
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic drain(input int budget);
      int n = 0;
      while ((q.size() + qp.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 32'(q.size() + qp.size()), 32'd0);
      q.delete();
      qp.delete();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.tx_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
   endtask

   // Sends one word through the default instance; optionally checks the wire.
   task automatic send(input logic [7:0] d, input bit expect_rx, input bit wave);
      logic [9:0] bits;
      wait_ready();
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      check("tx_ready_drop", 32'(bus.tx_ready), 32'd0);
      check("tx_busy_set", 32'(bus.tx_busy), 32'd1);
      check("uart_tx_start", 32'(uart_tx), 32'd0);
      if (expect_rx) q.push_back('{d, 1'b0, 1'b0, cyc});
      if (wave) begin
         bits = {1'b1, d, 1'b0};
         repeat (7) @(negedge clk);
         for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), 32'(uart_tx), 32'(bits[i]));
            repeat (CPB) @(negedge clk);
         end
      end
   endtask

   task automatic drive_ext(input logic [11:0] bits, input int n, input bit to_p);
      for (int i = 0; i < n; i++) begin
         if (to_p) ext_rx_p = bits[i];
         else      ext_rx   = bits[i];
         repeat (CPB) @(negedge clk);
      end
      ext_rx   = 1'b1;
      ext_rx_p = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   task automatic ext_frame(input logic [7:0] d, input logic stop);
      q.push_back('{d, 1'b0, ~stop, -1});
      drive_ext({2'b11, stop, d, 1'b0}, 10, 1'b0);
   endtask

   task automatic ext_par_frame(input logic [7:0] d, input logic par, input logic stop);
      qp.push_back('{d, par != odd_par(d), ~stop, -1});
      drive_ext({1'b1, stop, par, d, 1'b0}, 11, 1'b1);
   endtask

   initial begin
      logic [7:0] b2b [3];
      int         tprev;
      logic [7:0] r;
      b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C;
      tprev = 0;
      bus.tx_data = 8'h00;   bus.tx_valid = 1'b0;
      bus_p.tx_data = 8'h00; bus_p.tx_valid = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_uart_tx", 32'(uart_tx), 32'd1);
      check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      check("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data), 32'd0);
      check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      check("rst_rx_flags", 32'({bus.rx_parity_err, bus.rx_frame_err}), 32'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Single loopback frame with waveform and latency checks.
      send(8'hA5, 1'b1, 1'b1);
      drain(400);

      // Back-to-back frames with tx_valid held high.
      bus.tx_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ready();
         bus.tx_data = b2b[k];
         @(negedge clk);
         q.push_back('{b2b[k], 1'b0, 1'b0, cyc});
         check("b2b_ready_low", 32'(bus.tx_ready), 32'd0);
         if (k > 0) check("b2b_period", 32'(cyc - tprev), 32'd160);
         tprev = cyc;
      end
      bus.tx_valid = 1'b0;
      drain(600);

      // Random loopback words.
      for (int k = 0; k < 6; k++) begin
         r = 8'($urandom);
         send(r, 1'b1, 1'b0);
      end
      drain(600);

      // Odd-parity instance: directed then random external frames.
      ext_par_frame(8'h07, 1'b0, 1'b1);
      ext_par_frame(8'h07, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         r = 8'($urandom);
         ext_par_frame(r, odd_par(r) ^ 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
      drain(400);

      // External frames on the default instance: framing error, recovery, glitch.
      lb = 1'b0;
      repeat (2) @(negedge clk);
      ext_frame(8'h55, 1'b0);
      ext_frame(8'h12, 1'b1);
      ext_rx = 1'b0;
      repeat (5) @(negedge clk);
      ext_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      ext_frame(8'h81, 1'b1);
      for (int k = 0; k < 4; k++) begin
         r = 8'($urandom);
         ext_frame(r, ($urandom_range(0, 2) != 0));
      end
      drain(400);

      // Reset during data bit 4 of a looped-back frame.
      lb = 1'b1;
      repeat (2) @(negedge clk);
      send(8'hC3, 1'b0, 1'b0);
      repeat (85) @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_uart_tx", 32'(uart_tx), 32'd1);
      check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      check("mid_rst_tx_busy", 32'(bus.tx_busy), 32'd0);
      check("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      send(8'h5A, 1'b1, 1'b1);
      drain(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
